// File: rtl/branch_resolver_if.sv
// Fetch/execute handshake bundle for branch_resolver.
// master: pipeline side (pushes predictions, resolves jumps, consumes training/redirect).
// slave:  branch_resolver itself.
interface branch_resolver_if #(
    parameter int HIST_BITS = 7
);
    logic                 push_valid_i;
    logic [63:0]          push_pc_i;
    logic                 push_taken_i;
    logic [63:0]          push_alt_pc_i;
    logic [HIST_BITS-1:0] push_hist_i;
    logic                 push_ready_o;

    logic                 resolve_valid_i;
    logic [63:0]          resolve_pc_i;
    logic                 resolve_cnd_i;

    logic                 train_valid_o;
    logic [63:0]          train_pc_o;
    logic                 train_taken_o;
    logic                 train_mispredicted_o;
    logic [HIST_BITS-1:0] train_hist_o;

    logic                 redirect_valid_o;
    logic [63:0]          redirect_pc_o;
    logic [HIST_BITS-1:0] restore_hist_o;

    modport master (
        output push_valid_i, push_pc_i, push_taken_i, push_alt_pc_i, push_hist_i,
        input  push_ready_o,
        output resolve_valid_i, resolve_pc_i, resolve_cnd_i,
        input  train_valid_o, train_pc_o, train_taken_o, train_mispredicted_o, train_hist_o,
        input  redirect_valid_o, redirect_pc_o, restore_hist_o
    );

    modport slave (
        input  push_valid_i, push_pc_i, push_taken_i, push_alt_pc_i, push_hist_i,
        output push_ready_o,
        input  resolve_valid_i, resolve_pc_i, resolve_cnd_i,
        output train_valid_o, train_pc_o, train_taken_o, train_mispredicted_o, train_hist_o,
        output redirect_valid_o, redirect_pc_o, restore_hist_o
    );
endinterface

// File: rtl/branch_resolver.sv
// Execute-side branch resolver: in-order queue of gshare predictions, popped
// when the jump resolves, producing a registered training packet and, on a
// mispredict, a redirect PC plus corrected global history.
// Optional: define BRANCH_PERF_EN to build the resolved/mispredict counters.
module branch_resolver #(
    parameter int DEPTH     = 4,
    parameter int HIST_BITS = 7,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_resolver_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic                     pc_mismatch_o,
    output logic [CNT_W-1:0]         perf_branches_o,
    output logic [CNT_W-1:0]         perf_mispredicts_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef struct packed {
        logic [63:0]          pc;
        logic                 taken;
        logic [63:0]          alt_pc;
        logic [HIST_BITS-1:0] hist;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count;

    entry_t head_entry;
    logic   full;
    logic   empty;
    logic   pop;
    logic   mispred;
    logic   push_ok;
    logic   push_drop;

    // Queue status and the per-cycle push/pop/flush decisions.
    always_comb begin
        head_entry = mem[head];
        full       = (count == CW'(DEPTH));
        empty      = (count == '0);
        pop        = bus.resolve_valid_i && !empty;
        mispred    = pop && (bus.resolve_cnd_i ^ head_entry.taken);
        // A push alongside a mispredict is wrong-path: discarded, not an overflow.
        push_ok    = bus.push_valid_i && !full && !mispred;
        push_drop  = bus.push_valid_i && full && !mispred;
    end

    assign bus.push_ready_o = !full;
    assign count_o          = count;

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= '{pc:     bus.push_pc_i,
                           taken:  bus.push_taken_i,
                           alt_pc: bus.push_alt_pc_i,
                           hist:   bus.push_hist_i};
        end
    end

    // Pointers, occupancy, registered training/redirect outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            bus.train_valid_o        <= 1'b0;
            bus.train_pc_o           <= '0;
            bus.train_taken_o        <= 1'b0;
            bus.train_mispredicted_o <= 1'b0;
            bus.train_hist_o         <= '0;
            bus.redirect_valid_o     <= 1'b0;
            bus.redirect_pc_o        <= '0;
            bus.restore_hist_o       <= '0;
            overflow_o               <= 1'b0;
            underflow_o              <= 1'b0;
            pc_mismatch_o            <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            // Flush leaves the queue empty just past the popped head.
            if (mispred) begin
                tail  <= head + PTR_W'(1);
                count <= '0;
            end else begin
                count <= count + CW'(push_ok) - CW'(pop);
            end

            bus.train_valid_o    <= pop;
            bus.redirect_valid_o <= mispred;
            if (pop) begin
                bus.train_pc_o           <= head_entry.pc;
                bus.train_taken_o        <= bus.resolve_cnd_i;
                bus.train_mispredicted_o <= mispred;
                bus.train_hist_o         <= head_entry.hist;
            end
            if (mispred) begin
                bus.redirect_pc_o  <= head_entry.alt_pc;
                bus.restore_hist_o <= {head_entry.hist[HIST_BITS-2:0], bus.resolve_cnd_i};
            end

            if (push_drop) begin
                overflow_o <= 1'b1;
            end
            if (bus.resolve_valid_i && empty) begin
                underflow_o <= 1'b1;
            end
            if (pop && (bus.resolve_pc_i != head_entry.pc)) begin
                pc_mismatch_o <= 1'b1;
            end
        end
    end

`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] mispredicts;

    // Free-running performance counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            branches    <= '0;
            mispredicts <= '0;
        end else begin
            if (pop) begin
                branches <= branches + CNT_W'(1);
            end
            if (mispred) begin
                mispredicts <= mispredicts + CNT_W'(1);
            end
        end
    end

    assign perf_branches_o    = branches;
    assign perf_mispredicts_o = mispredicts;
`else
    assign perf_branches_o    = '0;
    assign perf_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, HIST_BITS=7).
module tb_branch_resolver;
    localparam int DEPTH = 4;
    localparam int HB    = 7;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic [2:0]       count_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             pc_mismatch_o;
    logic [CNT_W-1:0] perf_branches_o;
    logic [CNT_W-1:0] perf_mispredicts_o;

    int errors = 0;
    int checks = 0;

    branch_resolver_if #(.HIST_BITS(HB)) bus ();

    branch_resolver #(.DEPTH(DEPTH), .HIST_BITS(HB), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus.slave),
        .count_o            (count_o),
        .overflow_o         (overflow_o),
        .underflow_o        (underflow_o),
        .pc_mismatch_o      (pc_mismatch_o),
        .perf_branches_o    (perf_branches_o),
        .perf_mispredicts_o (perf_mispredicts_o)
    );

    always #5 clk = ~clk;

    // Advance one edge, sample point is 1 time unit after it; valids then drop.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.push_valid_i    = 1'b0;
        bus.resolve_valid_i = 1'b0;
    endtask

    task automatic set_push(input logic [63:0] pc, input logic taken,
                            input logic [63:0] alt, input logic [HB-1:0] hist);
        bus.push_valid_i  = 1'b1;
        bus.push_pc_i     = pc;
        bus.push_taken_i  = taken;
        bus.push_alt_pc_i = alt;
        bus.push_hist_i   = hist;
    endtask

    task automatic set_resolve(input logic [63:0] pc, input logic cnd);
        bus.resolve_valid_i = 1'b1;
        bus.resolve_pc_i    = pc;
        bus.resolve_cnd_i   = cnd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (bus.push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.push_ready_o); end
        checks++; if (bus.train_valid_o !== 1'b0) begin errors++; $display("FAIL reset_train_valid: got %b expected 0", bus.train_valid_o); end
        checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b expected 0", bus.redirect_valid_o); end
        checks++; if (bus.train_pc_o !== 64'h0) begin errors++; $display("FAIL reset_train_pc: got %h expected 0", bus.train_pc_o); end
        checks++; if ({overflow_o, underflow_o, pc_mismatch_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {overflow_o, underflow_o, pc_mismatch_o}); end
    endtask

    task automatic test_correct();
        set_push(64'h10, 1'b1, 64'h19, 7'h05);
        tick();
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL correct_count_push: got %0d expected 1", count_o); end
        set_resolve(64'h10, 1'b1);
        tick();
        checks++; if (bus.train_valid_o !== 1'b1) begin errors++; $display("FAIL correct_train_valid: got %b expected 1", bus.train_valid_o); end
        checks++; if (bus.train_mispredicted_o !== 1'b0) begin errors++; $display("FAIL correct_mispred: got %b expected 0", bus.train_mispredicted_o); end
        checks++; if (bus.train_hist_o !== 7'h05) begin errors++; $display("FAIL correct_hist: got %h expected 05", bus.train_hist_o); end
        checks++; if (bus.train_pc_o !== 64'h10) begin errors++; $display("FAIL correct_pc: got %h expected 10", bus.train_pc_o); end
        checks++; if (bus.train_taken_o !== 1'b1) begin errors++; $display("FAIL correct_taken: got %b expected 1", bus.train_taken_o); end
        checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL correct_redirect: got %b expected 0", bus.redirect_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL correct_count: got %0d expected 0", count_o); end
        tick();
        checks++; if (bus.train_valid_o !== 1'b0) begin errors++; $display("FAIL correct_valid_pulse: got %b expected 0", bus.train_valid_o); end
        checks++; if (bus.train_pc_o !== 64'h10) begin errors++; $display("FAIL correct_pc_hold: got %h expected 10", bus.train_pc_o); end
    endtask

    task automatic test_mispredict();
        set_push(64'h100, 1'b0, 64'h40, 7'h7F);
        tick();
        set_push(64'h200, 1'b1, 64'h204, 7'h11);
        tick();
        set_push(64'h300, 1'b1, 64'h304, 7'h23);
        tick();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL mis_count_fill: got %0d expected 3", count_o); end
        set_resolve(64'h100, 1'b1);
        tick();
        checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL mis_redirect_valid: got %b expected 1", bus.redirect_valid_o); end
        checks++; if (bus.redirect_pc_o !== 64'h40) begin errors++; $display("FAIL mis_redirect_pc: got %h expected 40", bus.redirect_pc_o); end
        checks++; if (bus.restore_hist_o !== 7'h7F) begin errors++; $display("FAIL mis_restore_hist: got %h expected 7f", bus.restore_hist_o); end
        checks++; if (bus.train_mispredicted_o !== 1'b1) begin errors++; $display("FAIL mis_train_mispred: got %b expected 1", bus.train_mispredicted_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL mis_count_flush: got %0d expected 0", count_o); end
`ifdef BRANCH_PERF_EN
        checks++; if (perf_mispredicts_o !== 32'd1) begin errors++; $display("FAIL mis_perf_mis: got %0d expected 1", perf_mispredicts_o); end
        checks++; if (perf_branches_o !== 32'd2) begin errors++; $display("FAIL mis_perf_br: got %0d expected 2", perf_branches_o); end
`else
        checks++; if ({perf_branches_o, perf_mispredicts_o} !== 64'h0) begin errors++; $display("FAIL mis_perf_tied: got %h expected 0", {perf_branches_o, perf_mispredicts_o}); end
`endif
        tick();
        checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL mis_redirect_pulse: got %b expected 0", bus.redirect_valid_o); end
    endtask

    task automatic test_flush_push();
        set_push(64'h500, 1'b1, 64'h504, 7'h01);
        tick();
        set_resolve(64'h500, 1'b0);
        set_push(64'h600, 1'b1, 64'h604, 7'h02);
        tick();
        checks++; if (bus.redirect_pc_o !== 64'h504) begin errors++; $display("FAIL flush_redirect_pc: got %h expected 504", bus.redirect_pc_o); end
        checks++; if (bus.restore_hist_o !== 7'h02) begin errors++; $display("FAIL flush_restore_hist: got %h expected 02", bus.restore_hist_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow_o); end
    endtask

    task automatic test_underflow();
        set_resolve(64'h700, 1'b1);
        tick();
        checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %b expected 1", underflow_o); end
        checks++; if (bus.train_valid_o !== 1'b0) begin errors++; $display("FAIL underflow_train: got %b expected 0", bus.train_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL underflow_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_pc_mismatch();
        checks++; if (pc_mismatch_o !== 1'b0) begin errors++; $display("FAIL pcm_before: got %b expected 0", pc_mismatch_o); end
        set_push(64'h10, 1'b1, 64'h14, 7'h03);
        tick();
        set_resolve(64'h20, 1'b1);
        tick();
        checks++; if (pc_mismatch_o !== 1'b1) begin errors++; $display("FAIL pcm_flag: got %b expected 1", pc_mismatch_o); end
        checks++; if (bus.train_valid_o !== 1'b1) begin errors++; $display("FAIL pcm_train_valid: got %b expected 1", bus.train_valid_o); end
        checks++; if (bus.train_pc_o !== 64'h10) begin errors++; $display("FAIL pcm_train_pc: got %h expected 10", bus.train_pc_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(64'h1000 + 64'(4 * i), 1'b0, 64'h1100 + 64'(i), 7'(i));
            tick();
        end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count_full: got %0d expected 4", count_o); end
        checks++; if (bus.push_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b expected 0", bus.push_ready_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow_o); end
        set_push(64'h2000, 1'b0, 64'h2004, 7'h09);
        tick();
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count_o); end
    endtask

    task automatic test_back_to_back();
        // Full queue: simultaneous push is still refused.
        set_resolve(64'h1000, 1'b0);
        set_push(64'h2000, 1'b0, 64'h2004, 7'h09);
        tick();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_count_full_pop: got %0d expected 3", count_o); end
        checks++; if (bus.train_pc_o !== 64'h1000) begin errors++; $display("FAIL b2b_pc0: got %h expected 1000", bus.train_pc_o); end
        set_resolve(64'h1004, 1'b0);
        set_push(64'h3000, 1'b1, 64'h3100, 7'h22);
        tick();
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL b2b_count_same: got %0d expected 3", count_o); end
        checks++; if (bus.train_pc_o !== 64'h1004) begin errors++; $display("FAIL b2b_pc1: got %h expected 1004", bus.train_pc_o); end
        set_resolve(64'h1008, 1'b0);
        tick();
        checks++; if (bus.train_hist_o !== 7'h02) begin errors++; $display("FAIL b2b_hist2: got %h expected 02", bus.train_hist_o); end
        set_resolve(64'h100C, 1'b0);
        tick();
        checks++; if (bus.train_pc_o !== 64'h100C) begin errors++; $display("FAIL b2b_pc3: got %h expected 100c", bus.train_pc_o); end
        set_resolve(64'h3000, 1'b1);
        tick();
        checks++; if (bus.train_pc_o !== 64'h3000) begin errors++; $display("FAIL b2b_pc_new: got %h expected 3000", bus.train_pc_o); end
        checks++; if (bus.train_hist_o !== 7'h22) begin errors++; $display("FAIL b2b_hist_new: got %h expected 22", bus.train_hist_o); end
        checks++; if ({bus.train_mispredicted_o, bus.redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL b2b_no_mispred: got %b expected 00", {bus.train_mispredicted_o, bus.redirect_valid_o}); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_count_end: got %0d expected 0", count_o); end
`ifdef BRANCH_PERF_EN
        checks++; if (perf_branches_o !== 32'd9) begin errors++; $display("FAIL b2b_perf_br: got %0d expected 9", perf_branches_o); end
        checks++; if (perf_mispredicts_o !== 32'd2) begin errors++; $display("FAIL b2b_perf_mis: got %0d expected 2", perf_mispredicts_o); end
`endif
    endtask

    task automatic test_reset_mid();
        set_push(64'h800, 1'b0, 64'h880, 7'h15);
        tick();
        set_push(64'h900, 1'b0, 64'h980, 7'h16);
        tick();
        set_resolve(64'h800, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_redirect_valid: got %b expected 0", bus.redirect_valid_o); end
        checks++; if (bus.train_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_train_valid: got %b expected 0", bus.train_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count_o); end
        checks++; if (bus.redirect_pc_o !== 64'h0) begin errors++; $display("FAIL rmid_redirect_pc: got %h expected 0", bus.redirect_pc_o); end
        checks++; if (bus.restore_hist_o !== 7'h0) begin errors++; $display("FAIL rmid_restore_hist: got %h expected 0", bus.restore_hist_o); end
        checks++; if (bus.train_pc_o !== 64'h0) begin errors++; $display("FAIL rmid_train_pc: got %h expected 0", bus.train_pc_o); end
        checks++; if ({overflow_o, underflow_o, pc_mismatch_o} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b expected 000", {overflow_o, underflow_o, pc_mismatch_o}); end
        checks++; if ({perf_branches_o, perf_mispredicts_o} !== 64'h0) begin errors++; $display("FAIL rmid_perf: got %h expected 0", {perf_branches_o, perf_mispredicts_o}); end
        tick();
        checks++; if ({bus.train_valid_o, bus.redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL rmid_no_late_out: got %b expected 00", {bus.train_valid_o, bus.redirect_valid_o}); end
    endtask

    initial begin
        reset               = 1'b1;
        bus.push_valid_i    = 1'b0;
        bus.push_pc_i       = '0;
        bus.push_taken_i    = 1'b0;
        bus.push_alt_pc_i   = '0;
        bus.push_hist_i     = '0;
        bus.resolve_valid_i = 1'b0;
        bus.resolve_pc_i    = '0;
        bus.resolve_cnd_i   = 1'b0;

        test_reset();
        test_correct();
        test_mispredict();
        test_flush_push();
        test_underflow();
        test_pc_mismatch();
        test_overflow();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-side partner of the fetch-stage gshare predictor in the y86 pipeline. Each fetched `IJXX` prediction is pushed into a small in-order queue together with its fall-back PC and the global history snapshot taken before the prediction. When the jump resolves in execute, the block pops the head entry and compares the predicted direction against `e_Cnd`. It then emits a registered training packet for the pattern table and, on a mispredict, a redirect PC plus a corrected history value. Wrong-path queue entries are discarded on a mispredict.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `HIST_BITS`, 7: global history width; matches the predictor index width.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  clock, one domain.
- `reset`  in  1  synchronous, active-high reset.
- `push_valid_i`  in  1  fetch issued an `IJXX` prediction this cycle.
- `push_pc_i`  in  64  PC of the jump.
- `push_taken_i`  in  1  predicted direction.
- `push_alt_pc_i`  in  64  PC not chosen by fetch: `valP` if predicted taken, `valC` otherwise.
- `push_hist_i`  in  HIST_BITS  global history before this prediction.
- `push_ready_o`  out  1  queue not full.
- `resolve_valid_i`  in  1  an `IJXX` is in execute this cycle.
- `resolve_pc_i`  in  64  `E_PC` of that jump.
- `resolve_cnd_i`  in  1  `e_Cnd`, the actual direction.
- `train_valid_o`  out  1  training packet valid.
- `train_pc_o`  out  64  PC of the trained jump.
- `train_taken_o`  out  1  actual direction.
- `train_mispredicted_o`  out  1  prediction was wrong.
- `train_hist_o`  out  HIST_BITS  history snapshot stored with the entry.
- `redirect_valid_o`  out  1  fetch must restart at `redirect_pc_o`.
- `redirect_pc_o`  out  64  corrected fetch PC.
- `restore_hist_o`  out  HIST_BITS  corrected history, `{train_hist[HIST_BITS-2:0], cnd}`.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow_o`  out  1  sticky flag: a push was dropped.
- `underflow_o`  out  1  sticky flag: a resolve arrived with the queue empty.
- `pc_mismatch_o`  out  1  sticky flag: `resolve_pc_i` differed from the head entry PC.
- `perf_branches_o`  out  CNT_W  resolved jump count (only with `BRANCH_PERF_EN`).
- `perf_mispredicts_o`  out  CNT_W  mispredict count (only with `BRANCH_PERF_EN`).

## Operation
- Storage is a circular FIFO with head and tail pointers that wrap modulo `DEPTH`. Occupancy is held in a separate counter, so full and empty are unambiguous.
- Push: accepted when `push_valid_i` is high and `count_o < DEPTH`.
  - A push while full is dropped and sets `overflow_o`.
  - This holds even if a pop occurs in the same cycle; `push_ready_o` is `!full` and has no dependence on a simultaneous pop.
- Resolve with queue non-empty: pop the head entry.
  - `mispred = resolve_cnd_i ^ head.taken`.
  - Latch the `train_*` outputs from the head entry and `resolve_cnd_i`.
- Resolve with queue empty: no pop, no training; set `underflow_o`.
- PC check: if `resolve_pc_i != head.pc`, set `pc_mismatch_o`. The pop and training still proceed using head data.
- Mispredict:
  - Set `redirect_valid_o` and `redirect_pc_o = head.alt_pc`, and set `restore_hist_o`.
  - Flush every remaining entry (all are wrong-path): count goes to 0 and tail is set equal to head.
  - A push in the same cycle is discarded and does not set `overflow_o`.
- Correct prediction with a simultaneous push: pop and push both take effect; count is unchanged.
- Sticky flags clear only on `reset`.

## Timing
- Reset values:
  - Count 0, pointers 0, `push_ready_o` = 1.
  - All `*_valid_o` = 0.
  - `train_pc_o`, `redirect_pc_o`, `train_hist_o` and `restore_hist_o` = 0; `train_taken_o` and `train_mispredicted_o` = 0.
  - All sticky flags = 0; perf counters = 0.
- Latency: resolve in cycle N gives `train_*` and `redirect_*` valid in cycle N+1, for exactly one cycle.
- Payload outputs hold their last value while the corresponding valid is low.
- `count_o` and `push_ready_o` reflect state after the edge; a push in cycle N is poppable by a resolve in cycle N+1.
- Reset asserted mid-operation: all state is cleared on the next edge, and no training or redirect is emitted for in-flight entries.

## Configuration
- `BRANCH_PERF_EN` defined:
  - `perf_branches_o` increments on every pop.
  - `perf_mispredicts_o` increments on every mispredict pop.
  - Both wrap modulo 2^CNT_W.
- `BRANCH_PERF_EN` undefined: both perf ports are tied to 0 and no counter flops are built.

## Test plan
- Push PC 0x10, taken=1, alt 0x19, hist 0x05; next cycle resolve cnd=1 -> N+1: `train_valid_o`=1, `train_mispredicted_o`=0, `train_hist_o`=0x05, `redirect_valid_o`=0, `count_o`=0.
- Push three entries (first: taken=0, alt 0x40, hist 0x7F); resolve cnd=1 -> `redirect_pc_o`=0x40, `restore_hist_o`=0x7F, `count_o`=0, perf mispredicts 1.
- Fill to `DEPTH`=4, then push again -> `push_ready_o`=0, push dropped, `overflow_o`=1, `count_o`=4.
- Resolve with queue empty -> `underflow_o`=1, `train_valid_o` stays 0.
- Resolve with `resolve_pc_i`=0x20 while head PC is 0x10 -> `pc_mismatch_o`=1, training still issued for 0x10.
- Push 2 entries, assert `reset` in the same cycle as a mispredicting resolve -> next cycle all outputs at reset values, `redirect_valid_o`=0.
